// File: rtl/osd_trace_depacketization.sv
// Rebuilds one trace sample per DII trace-event packet: destination, header, then payload or status flits.
// Malformed packets are consumed, discarded and flagged with a single pkt_error pulse.
`timescale 1ns/1ps

package osd_trace_depacketization_pkg;
   typedef struct packed {
      logic        valid;
      logic        last;
      logic [15:0] data;
   } dii_flit;
endpackage

module osd_trace_depacketization
   import osd_trace_depacketization_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  dii_flit          debug_in,
   output logic             debug_in_ready,
   output logic [WIDTH-1:0] trace_data,
   output logic             trace_overflow,
   output logic [9:0]       trace_id,
   output logic [15:0]      trace_dest,
   output logic             trace_valid,
   input  logic             trace_ready,
   output logic             pkt_error
);

   localparam int unsigned NUM_FLITS = (WIDTH + 15) / 16;
   localparam int unsigned CNT_W     = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;

   typedef enum logic [2:0] {
      ST_DEST, ST_SOURCE, ST_PAYLOAD, ST_STATUS, ST_OUTPUT, ST_DROP
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic               ovf_q, ovf_d;
   logic [9:0]         id_q, id_d;
   logic [15:0]        dest_q, dest_d;
   logic               err_q, err_d;

   logic               accept;
   logic               final_flit;
   logic               hdr_ok;
   logic [CNT_W+3:0]   shamt;
   logic [WIDTH-1:0]   pay_merged;

   assign accept     = debug_in.valid && (state_q != ST_OUTPUT);
   assign final_flit = (cnt_q == CNT_W'(NUM_FLITS - 1));
   assign hdr_ok     = (debug_in.data[15:14] == 2'h2) && !debug_in.data[10];
   assign shamt      = {cnt_q, 4'b0000};

   // Bits beyond WIDTH fall off the truncating casts, so fill bits of the last flit are ignored.
   assign pay_merged = (data_q & ~WIDTH'({{WIDTH{1'b0}}, 16'hFFFF} << shamt))
                     | WIDTH'({{WIDTH{1'b0}}, debug_in.data} << shamt);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      ovf_d   = ovf_q;
      id_d    = id_q;
      dest_d  = dest_q;
      err_d   = 1'b0;
      case (state_q)
         ST_DEST: if (accept) begin
            dest_d = debug_in.data;
            if (debug_in.last) err_d = 1'b1;
            else               state_d = ST_SOURCE;
         end
         ST_SOURCE: if (accept) begin
            id_d   = debug_in.data[9:0];
            cnt_d  = '0;
            data_d = '0;
            if (!hdr_ok) begin
               err_d   = 1'b1;
               state_d = debug_in.last ? ST_DEST : ST_DROP;
            end else if (debug_in.last) begin
               err_d   = 1'b1;
               state_d = ST_DEST;
            end else begin
               state_d = debug_in.data[11] ? ST_STATUS : ST_PAYLOAD;
            end
         end
         ST_STATUS: if (accept) begin
            if (!debug_in.data[15] || !debug_in.last) begin
               err_d   = 1'b1;
               state_d = debug_in.last ? ST_DEST : ST_DROP;
            end else begin
               data_d  = WIDTH'(debug_in.data[9:0]);
               ovf_d   = 1'b1;
               state_d = ST_OUTPUT;
            end
         end
         ST_PAYLOAD: if (accept) begin
            data_d = pay_merged;
            if (!final_flit) begin
               if (debug_in.last) begin
                  err_d   = 1'b1;
                  state_d = ST_DEST;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else if (debug_in.last) begin
               ovf_d   = 1'b0;
               state_d = ST_OUTPUT;
            end else begin
               err_d   = 1'b1;
               state_d = ST_DROP;
            end
         end
         ST_OUTPUT: if (trace_ready) state_d = ST_DEST;
         ST_DROP:   if (accept && debug_in.last) state_d = ST_DEST;
         default:   state_d = ST_DEST;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_DEST;
         cnt_q   <= '0;
         data_q  <= '0;
         ovf_q   <= 1'b0;
         id_q    <= '0;
         dest_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         ovf_q   <= ovf_d;
         id_q    <= id_d;
         dest_q  <= dest_d;
         err_q   <= err_d;
      end
   end

   assign debug_in_ready = (state_q != ST_OUTPUT);
   assign trace_valid    = (state_q == ST_OUTPUT);
   assign trace_data     = data_q;
   assign trace_overflow = ovf_q;
   assign trace_id       = id_q;
   assign trace_dest     = dest_q;
   assign pkt_error      = err_q;

endmodule
